multiport_register_file: RTL and testbench
==========================================

Name: multiport_register_file

Overview:
Parametrised successor to the single-write, dual-read CPU register file, with N write ports and M read ports. Adds same-cycle write-to-read bypass, deterministic write-conflict priority and a per-register pending (scoreboard) bit for hazard detection. Sits in the decode/writeback boundary of the pipelined core. Also serves future dual-issue configurations.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, number of architectural registers
ADDR_W, 5, register index width; must equal clog2(NUM_REGS)
NUM_RD, 4, number of read ports
NUM_WR, 2, number of write ports
BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads; 0 = reads see stored state only
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never pending

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
wr_en  input  NUM_WR  per-port write enable
wr_addr  input  NUM_WR*ADDR_W  write indices; port k occupies bits [k*ADDR_W +: ADDR_W]
wr_data  input  NUM_WR*DATA_W  write data, packed the same way
rd_addr  input  NUM_RD*ADDR_W  read indices, packed
rd_data  output  NUM_RD*DATA_W  read data, packed
pend_set_en  input  1  mark a register as awaiting a result (producer issued)
pend_set_addr  input  ADDR_W  register to mark pending
rd_pending  output  NUM_RD  per read port: the addressed register's value is not yet available

Behaviour:
- Reset:
  - Applies when rst_n=0 at a rising edge of clk.
  - All registers clear to 0 and all pending bits clear.
  - Writes and pend_set are ignored in a reset cycle; reset wins over every simultaneous event.
  - While rst_n=0, bypass and rd_pending are forced to 0.
  - After the reset edge, every rd_data=0 and every rd_pending=0.
- Write:
  - At a rising edge, when wr_en[k]=1, registers[wr_addr[k]] takes wr_data[k].
  - Write latency is 1 edge.
- Write conflict: when several enabled ports target the same address in one cycle, the highest-index port wins.
- Register 0 (ZERO_REG=1):
  - Writes are dropped.
  - Reads return 0 regardless of bypass.
  - The pending bit is never set.
- Read path:
  - Combinational, zero latency: rd_data[j] = registers[rd_addr[j]].
  - With BYPASS=1, if any enabled write port matches rd_addr[j] in the same cycle, rd_data[j] = that port's wr_data, using the highest matching index.
  - With BYPASS=0, the new value is visible the cycle after the write.
- Out-of-range index (NUM_REGS not a power of two, address >= NUM_REGS):
  - Writes are ignored.
  - Reads return 0 and rd_pending=0.
- Pending scoreboard (one bit per register):
  - Set at the edge where pend_set_en=1 for pend_set_addr.
  - Cleared at the edge where any enabled write port targets that register.
  - If a set and a clear hit the same register at the same edge, the set wins: a new producer is issued.
  - rd_pending[j] = pending[rd_addr[j]], AND NOT (BYPASS=1 and a same-cycle enabled write matches rd_addr[j]).
  - A pend_set becomes visible on rd_pending the cycle after it is issued.
- No internal FSM beyond the register array and the pending vector. All outputs are combinational from state plus same-cycle write inputs. No output is registered.

Test Plan:
- Reset and write-read:
  - Stimulus: hold rst_n=0 for 2 edges and read all ports; release; write reg 5=0xDEADBEEF via port 0; read reg 5 on all 4 ports the next cycle.
  - Required: 0 on all ports during reset; 0xDEADBEEF on all 4 ports after the write.
- Bypass:
  - Stimulus: BYPASS=1; in the same cycle, write reg 7=0x12345678 via port 1 and read reg 7.
  - Required: rd_data=0x12345678 in that cycle.
  - Repeat with BYPASS=0. Required: old value (0) in that cycle, 0x12345678 the next cycle.
- Write conflict:
  - Stimulus: port 0 writes reg 3=0xAAAA0000 and port 1 writes reg 3=0x5555FFFF in the same cycle.
  - Required: reg 3 reads 0x5555FFFF afterwards; the bypass read in the same cycle also returns 0x5555FFFF.
- Register 0:
  - Stimulus: write reg 0=0xFFFFFFFF on both ports; pend_set reg 0.
  - Required: reg 0 reads 0; rd_pending=0 on the read port addressing reg 0.
- Scoreboard:
  - Stimulus: pend_set reg 9, then read reg 9.
  - Required: rd_pending=1 from the next cycle.
  - Stimulus: write reg 9 via port 0.
  - Required: rd_pending=0 in the write cycle (bypass) and after it.
  - Stimulus: pend_set reg 9 and write reg 9 in the same cycle.
  - Required: rd_pending=1 the next cycle.
- Reset mid-operation:
  - Stimulus: write regs 1-31 and set several pending bits; assert rst_n=0 for 1 edge while wr_en=2'b11 and pend_set_en=1.
  - Required: all registers 0, no pending bits, and none of the simultaneous writes or pend_set take effect.

Source files
------------

// File: rtl/multiport_register_file.sv
// N-write / M-read register file with same-cycle bypass
// and a per-register pending scoreboard.
module multiport_register_file #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 4,
  parameter int NUM_WR   = 2,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic                       pend_set_en,
  input  logic [ADDR_W-1:0]          pend_set_addr,
  output logic [NUM_RD-1:0]          rd_pending
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending;

  logic [ADDR_W-1:0] wa [NUM_WR];
  logic [DATA_W-1:0] wd [NUM_WR];
  logic              wv [NUM_WR];
  logic              ps_v;

  function automatic logic in_range(
    input logic [ADDR_W-1:0] a
  );
    return {1'b0, a} < (ADDR_W+1)'(NUM_REGS);
  endfunction

  function automatic logic is_zero(
    input logic [ADDR_W-1:0] a
  );
    return ZERO_REG && (a == '0);
  endfunction

  // A write is effective only for a real, writable register
  always_comb begin
    for (int k = 0; k < NUM_WR; k++) begin
      wa[k] = wr_addr[k*ADDR_W +: ADDR_W];
      wd[k] = wr_data[k*DATA_W +: DATA_W];
      wv[k] = wr_en[k] && in_range(wa[k])
              && !is_zero(wa[k]);
    end
    ps_v = pend_set_en && in_range(pend_set_addr)
           && !is_zero(pend_set_addr);
  end

  // Later ports overwrite earlier ones: highest index wins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
      pending <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wv[k]) begin
          regs[wa[k]]    <= wd[k];
          pending[wa[k]] <= 1'b0;
        end
      end
      if (ps_v)
        pending[pend_set_addr] <= 1'b1;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] d;
    logic              p;
    rd_data    = '0;
    rd_pending = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      ra = rd_addr[j*ADDR_W +: ADDR_W];
      d  = '0;
      p  = 1'b0;
      if (in_range(ra)) begin
        d = regs[ra];
        p = pending[ra];
      end
      if (BYPASS && rst_n) begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (wv[k] && wa[k] == ra) begin
            d = wd[k];
            p = 1'b0;
          end
        end
      end
      if (is_zero(ra)) begin
        d = '0;
        p = 1'b0;
      end
      if (!rst_n)
        p = 1'b0;
      rd_data[j*DATA_W +: DATA_W] = d;
      rd_pending[j]               = p;
    end
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Randomised bench for multiport_register_file: bypass and
// non-bypass instances checked against an array-based model.
module tb_multiport_register_file;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   wr_en;
  logic [9:0]   wr_addr;
  logic [63:0]  wr_data;
  logic [19:0]  rd_addr;
  logic [127:0] rd_data_b, rd_data_n;
  logic         pend_set_en;
  logic [4:0]   pend_set_addr;
  logic [3:0]   rd_pend_b, rd_pend_n;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [32];
  bit          pnd [32];

  always #5 clk = ~clk;

  multiport_register_file #(.BYPASS(1'b1)) u_byp (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_b),
    .pend_set_en(pend_set_en), .pend_set_addr(pend_set_addr),
    .rd_pending(rd_pend_b)
  );

  multiport_register_file #(.BYPASS(1'b0)) u_nob (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_n),
    .pend_set_en(pend_set_en), .pend_set_addr(pend_set_addr),
    .rd_pending(rd_pend_n)
  );

  task automatic chk(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] wa(input int k);
    logic [9:0] v = wr_addr;
    return v[k*5 +: 5];
  endfunction

  function automatic logic [31:0] wd(input int k);
    logic [63:0] v = wr_data;
    return v[k*32 +: 32];
  endfunction

  function automatic logic [4:0] ra(input int j);
    logic [19:0] v = rd_addr;
    return v[j*5 +: 5];
  endfunction

  // Register 0 is hard zero; a live write (last port wins)
  // is forwarded when bypassing and the part is out of reset
  function automatic logic [31:0] exp_d(
    input logic [4:0] a, input bit byp
  );
    logic [31:0] v;
    if (a == 0) return 32'h0;
    v = mem[a];
    if (byp && rst_n)
      for (int k = 0; k < 2; k++)
        if (wr_en[k] && wa(k) == a) v = wd(k);
    return v;
  endfunction

  function automatic logic exp_p(
    input logic [4:0] a, input bit byp
  );
    if (!rst_n || a == 0) return 1'b0;
    if (byp)
      for (int k = 0; k < 2; k++)
        if (wr_en[k] && wa(k) == a) return 1'b0;
    return pnd[a];
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        mem[i] = 32'h0;
        pnd[i] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++)
        if (wr_en[k] && wa(k) != 0) begin
          mem[wa(k)] = wd(k);
          pnd[wa(k)] = 1'b0;
        end
      if (pend_set_en && pend_set_addr != 0)
        pnd[pend_set_addr] = 1'b1;
    end
  endtask

  task automatic tick();
    #1;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("byp_d%0d", j),
          rd_data_b[j*32 +: 32], exp_d(ra(j), 1));
      chk($sformatf("nob_d%0d", j),
          rd_data_n[j*32 +: 32], exp_d(ra(j), 0));
      chk($sformatf("byp_p%0d", j),
          32'(rd_pend_b[j]), 32'(exp_p(ra(j), 1)));
      chk($sformatf("nob_p%0d", j),
          32'(rd_pend_n[j]), 32'(exp_p(ra(j), 0)));
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr_en       = 2'b00;
    pend_set_en = 1'b0;
  endtask

  task automatic rd_all(input logic [4:0] a);
    rd_addr = {a, a, a, a};
  endtask

  task automatic wr(
    input int k, input logic [4:0] a, input logic [31:0] d
  );
    wr_en[k]          = 1'b1;
    wr_addr[k*5 +: 5] = a;
    wr_data[k*32 +: 32] = d;
  endtask

  task automatic pset(input logic [4:0] a);
    pend_set_en   = 1'b1;
    pend_set_addr = a;
  endtask

  task automatic all_ports(
    input string tag, input logic [31:0] eb,
    input logic [31:0] en
  );
    for (int j = 0; j < 4; j++) begin
      chk({tag, "_b"}, rd_data_b[j*32 +: 32], eb);
      chk({tag, "_n"}, rd_data_n[j*32 +: 32], en);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = 32'h0;
      pnd[i] = 1'b0;
    end
    rst_n = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    pend_set_addr = '0;
    idle();
    rd_all(5'd5);
    @(posedge clk);
    #1;
    tick();
    all_ports("rst", 32'h0, 32'h0);
    chk("rst_pend", 32'(rd_pend_b | rd_pend_n), 32'h0);
    rst_n = 1'b1;

    wr(0, 5'd5, 32'hDEADBEEF);
    tick();
    idle();
    #1;
    all_ports("wr5", 32'hDEADBEEF, 32'hDEADBEEF);
    tick();

    wr(1, 5'd7, 32'h12345678);
    rd_all(5'd7);
    #1;
    all_ports("byp7", 32'h12345678, 32'h0);
    tick();
    idle();
    #1;
    all_ports("post7", 32'h12345678, 32'h12345678);
    tick();

    wr(0, 5'd3, 32'hAAAA0000);
    wr(1, 5'd3, 32'h5555FFFF);
    rd_all(5'd3);
    #1;
    all_ports("conf_byp", 32'h5555FFFF, 32'h0);
    tick();
    idle();
    #1;
    all_ports("conf", 32'h5555FFFF, 32'h5555FFFF);
    tick();

    wr(0, 5'd0, 32'hFFFFFFFF);
    wr(1, 5'd0, 32'hFFFFFFFF);
    pset(5'd0);
    rd_all(5'd0);
    tick();
    idle();
    #1;
    all_ports("r0", 32'h0, 32'h0);
    chk("r0_pend", 32'(rd_pend_b | rd_pend_n), 32'h0);
    tick();

    pset(5'd9);
    rd_all(5'd9);
    tick();
    idle();
    #1;
    chk("p9_b", 32'(rd_pend_b), 32'hF);
    chk("p9_n", 32'(rd_pend_n), 32'hF);
    tick();
    wr(0, 5'd9, 32'h00000909);
    #1;
    chk("p9_wr_b", 32'(rd_pend_b), 32'h0);
    chk("p9_wr_n", 32'(rd_pend_n), 32'hF);
    tick();
    idle();
    #1;
    chk("p9_clr", 32'(rd_pend_b | rd_pend_n), 32'h0);
    tick();
    pset(5'd9);
    wr(0, 5'd9, 32'h00009999);
    tick();
    idle();
    #1;
    chk("p9_set_b", 32'(rd_pend_b), 32'hF);
    chk("p9_set_n", 32'(rd_pend_n), 32'hF);
    tick();

    for (int n = 0; n < 400; n++) begin
      rst_n         = ($urandom_range(0, 39) != 0);
      wr_en         = 2'($urandom);
      wr_addr       = 10'($urandom_range(0, 1023) & 10'h0E7);
      wr_data       = {$urandom, $urandom};
      rd_addr       = 20'($urandom) & 20'h739CE;
      pend_set_en   = ($urandom_range(0, 2) == 0);
      pend_set_addr = 5'($urandom) & 5'h0F;
      if (n % 5 == 0) rd_addr[4:0] = wr_addr[4:0];
      if (n % 7 == 0) rd_addr[9:5] = wr_addr[9:5];
      tick();
    end
    rst_n = 1'b1;

    for (int i = 1; i < 32; i++) begin
      idle();
      wr(0, 5'(i), $urandom);
      if (i % 3 == 0) pset(5'(i));
      tick();
    end
    rst_n = 1'b0;
    wr(0, 5'd4, 32'hCAFE0004);
    wr(1, 5'd6, 32'hCAFE0006);
    pset(5'd10);
    tick();
    rst_n = 1'b1;
    idle();
    for (int g = 0; g < 8; g++) begin
      rd_addr = {5'(4*g+3), 5'(4*g+2), 5'(4*g+1), 5'(4*g)};
      #1;
      all_ports("mid_rst", 32'h0, 32'h0);
      chk("mid_pend", 32'(rd_pend_b | rd_pend_n), 32'h0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
